// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: set-2 scancodes, byte-FSM states,
// held-key indices and osd_command bit positions.
package kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_E0   = 8'hE0;
  localparam logic [7:0] SC_E1   = 8'hE1;
  localparam logic [7:0] SC_F0   = 8'hF0;

  // Key codes (ext flag distinguishes left/right and Del/keypad '.')
  localparam logic [7:0] SC_F11  = 8'h78;
  localparam logic [7:0] SC_F12  = 8'h07;
  localparam logic [7:0] SC_SCRL = 8'h7E;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_ALT  = 8'h11;
  localparam logic [7:0] SC_DEL  = 8'h71;

  // Bytes swallowed after E1 (rest of the Pause make/break sequence)
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXT    = 3'd1,
    BRK    = 3'd2,
    EXTBRK = 3'd3,
    PAUSE  = 3'd4
  } kbd_state_e;

  // Held-flag vector layout
  localparam int K_F12    = 0;
  localparam int K_F11    = 1;
  localparam int K_SCRL   = 2;
  localparam int K_LCTRL  = 3;
  localparam int K_RCTRL  = 4;
  localparam int K_LALT   = 5;
  localparam int K_RALT   = 6;
  localparam int K_DEL    = 7;
  localparam int NUM_KEYS = 8;

  // osd_command bit positions
  localparam int OSD_SCRL_BIT = 0;
  localparam int OSD_F12_BIT  = 1;
  localparam int OSD_F11_BIT  = 2;

  // One-hot match of a decoded code against the tracked keys
  function automatic logic [NUM_KEYS-1:0] key_match(input logic [7:0] code, input logic ext);
    logic [NUM_KEYS-1:0] m;
    m          = '0;
    m[K_F12]   = !ext && (code == SC_F12);
    m[K_F11]   = !ext && (code == SC_F11);
    m[K_SCRL]  = !ext && (code == SC_SCRL);
    m[K_LCTRL] = !ext && (code == SC_CTRL);
    m[K_RCTRL] =  ext && (code == SC_CTRL);
    m[K_LALT]  = !ext && (code == SC_ALT);
    m[K_RALT]  =  ext && (code == SC_ALT);
    m[K_DEL]   =  ext && (code == SC_DEL);
    return m;
  endfunction

endpackage

// File: rtl/specialkey_scanner_if.sv
// Scancode byte input plus special-key level outputs.
interface specialkey_scanner_if;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       key_blksbr;
  logic       key_osd;
  logic [7:0] osd_command;
  logic       o_warm_reset;
  logic       o_f11_make;

  // Byte source / consumer side
  modport master (
    output scan_data, scan_valid,
    input  key_blksbr, key_osd, osd_command, o_warm_reset, o_f11_make
  );

  // Scanner side
  modport slave (
    input  scan_data, scan_valid,
    output key_blksbr, key_osd, osd_command, o_warm_reset, o_f11_make
  );
endinterface

// File: rtl/specialkey_scanner_pulse_stretch.sv
// Stretches a single-cycle trigger into a RESET_LEN-cycle level.
// Triggers while the level is already high are dropped (no extension).
module pulse_stretch #(
  parameter logic [15:0] RESET_LEN = 16'd1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  output logic pulse
);

  logic [15:0] cnt;

  // Load on trigger when idle, count down to 0, then drop the level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (!pulse) begin
      if (trig) begin
        pulse <= 1'b1;
        cnt   <= RESET_LEN - 16'd1;
      end
    end else if (cnt == '0) begin
      pulse <= 1'b0;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/specialkey_scanner.sv
// PS/2 set-2 byte stream -> special-key levels (F12, ScrollLock, F11)
// and a Ctrl+Alt+Del warm-reset pulse. Tracks E0/F0 prefixes, swallows
// Pause, ignores typematic repeats, abandons stale prefixes.
module specialkey_scanner
  import kbd_pkg::*;
#(
  parameter logic [23:0] PREFIX_TIMEOUT = 24'd3000000,
  parameter logic [15:0] RESET_LEN      = 16'd1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  specialkey_scanner_if.slave  kif
);

  kbd_state_e          state;
  logic [2:0]          skip;
  logic [23:0]         tcnt;
  logic [NUM_KEYS-1:0] held;
  logic                f11_make_q;

  logic                ev_make, ev_break, ev_ext;
  logic [NUM_KEYS-1:0] hit;
  logic                ctrl, alt, warm_trig;
  logic [7:0]          osd;

  // Classify the current byte as make / break / prefix for this state
  always_comb begin
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (kif.scan_valid) begin
      case (state)
        IDLE: ev_make = (kif.scan_data != SC_E0) && (kif.scan_data != SC_F0) &&
                        (kif.scan_data != SC_E1);
        EXT: begin
          ev_make = (kif.scan_data != SC_F0) && (kif.scan_data != SC_E0);
          ev_ext  = 1'b1;
        end
        BRK:    ev_break = 1'b1;
        EXTBRK: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hit  = key_match(kif.scan_data, ev_ext);
  assign ctrl = held[K_LCTRL] | held[K_RCTRL];
  assign alt  = held[K_LALT]  | held[K_RALT];
  // Only the fresh press of Del counts, so typematic Del repeats never re-fire
  assign warm_trig = ev_make && hit[K_DEL] && !held[K_DEL] && ctrl && alt;

  // Prefix FSM with idle timeout; a byte always takes priority over timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      skip  <= '0;
      tcnt  <= '0;
    end else if (kif.scan_valid) begin
      tcnt <= '0;
      case (state)
        IDLE: begin
          if (kif.scan_data == SC_E0)      state <= EXT;
          else if (kif.scan_data == SC_F0) state <= BRK;
          else if (kif.scan_data == SC_E1) begin
            state <= PAUSE;
            skip  <= PAUSE_SKIP;
          end
        end
        EXT: begin
          if (kif.scan_data == SC_F0)      state <= EXTBRK;
          else if (kif.scan_data != SC_E0) state <= IDLE;
        end
        PAUSE: begin
          skip <= skip - 3'd1;
          if (skip == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tcnt == PREFIX_TIMEOUT - 24'd1) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + 24'd1;
      end
    end else begin
      tcnt <= '0;
    end
  end

  // Held flags and the F11 press strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held       <= '0;
      f11_make_q <= 1'b0;
    end else begin
      f11_make_q <= ev_make && hit[K_F11] && !held[K_F11];
      if (ev_make)       held <= held | hit;
      else if (ev_break) held <= held & ~hit;
    end
  end

  // OSD command word from the held flags
  always_comb begin
    osd               = '0;
    osd[OSD_SCRL_BIT] = held[K_SCRL];
    osd[OSD_F12_BIT]  = held[K_F12];
    osd[OSD_F11_BIT]  = held[K_F11];
  end

  assign kif.key_blksbr  = held[K_F12];
  assign kif.key_osd     = held[K_SCRL];
  assign kif.osd_command = osd;
  assign kif.o_f11_make  = f11_make_q;

  pulse_stretch #(.RESET_LEN(RESET_LEN)) u_warm (
    .clk     (clk),
    .reset_n (reset_n),
    .trig    (warm_trig),
    .pulse   (kif.o_warm_reset)
  );

endmodule

// File: tb/tb_specialkey_scanner.sv
// Self-checking bench: directed table, hand sequences for multi-cycle
// corners, and random byte streams against a key-level reference model.
module tb_specialkey_scanner;
  localparam int T_OUT = 40;
  localparam int R_LEN = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wr_cycles = 0;

  specialkey_scanner_if kif ();

  specialkey_scanner #(
    .PREFIX_TIMEOUT (24'd40),
    .RESET_LEN      (16'd1024)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit    m_held[string];
  bit    m_ext, m_brk, m_f11p;
  int    m_pause, m_gap, m_wr_left;

  function automatic bit h(input string n);
    return m_held.exists(n) ? m_held[n] : 1'b0;
  endfunction

  function automatic string key_of(input bit ext, input logic [7:0] code);
    logic [8:0] k;
    k = {ext, code};
    case (k)
      9'h007: return "F12";
      9'h078: return "F11";
      9'h07E: return "SCRL";
      9'h014: return "LCTRL";
      9'h114: return "RCTRL";
      9'h011: return "LALT";
      9'h111: return "RALT";
      9'h171: return "DEL";
      default: return "";
    endcase
  endfunction

  task automatic m_make(input bit ext, input logic [7:0] code, inout bit trig);
    string s;
    s = key_of(ext, code);
    if (s == "" || h(s)) return;
    if (s == "DEL" && (h("LCTRL") || h("RCTRL")) && (h("LALT") || h("RALT"))) trig = 1;
    m_held[s] = 1;
    if (s == "F11") m_f11p = 1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rst);
    bit trig, was_active;
    if (rst) begin
      m_held.delete();
      m_ext = 0; m_brk = 0; m_f11p = 0;
      m_pause = 0; m_gap = 0; m_wr_left = 0;
      return;
    end
    trig = 0;
    m_f11p = 0;
    was_active = (m_wr_left > 0);
    if (!v) begin
      if (m_ext || m_brk || m_pause > 0) begin
        m_gap++;
        if (m_gap >= T_OUT) begin
          m_ext = 0; m_brk = 0; m_pause = 0; m_gap = 0;
        end
      end
    end else begin
      m_gap = 0;
      if (m_pause > 0) m_pause--;
      else if (m_brk) begin
        string s;
        s = key_of(m_ext, d);
        if (s != "") m_held[s] = 0;
        m_brk = 0; m_ext = 0;
      end else if (m_ext) begin
        if (d == 8'hF0) m_brk = 1;
        else if (d != 8'hE0) begin
          m_make(1, d, trig);
          m_ext = 0;
        end
      end else begin
        if (d == 8'hE0)      m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else if (d == 8'hE1) m_pause = 7;
        else m_make(0, d, trig);
      end
    end
    if (was_active) m_wr_left--;
    else if (trig) m_wr_left = R_LEN;
  endtask

  // ---------------- checking / driving ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit rst);
    kif.scan_valid = v;
    kif.scan_data  = v ? d : 8'($urandom);
    reset_n        = !rst;
    @(posedge clk);
    model_step(v, d, rst);
    #1;
    chk("key_blksbr", kif.key_blksbr, h("F12"));
    chk("key_osd", kif.key_osd, h("SCRL"));
    chk("osd_command", kif.osd_command, {5'b0, h("F11"), h("F12"), h("SCRL")});
    chk("o_f11_make", kif.o_f11_make, m_f11p);
    chk("o_warm_reset", kif.o_warm_reset, m_wr_left > 0);
    if (kif.o_warm_reset) wr_cycles++;
  endtask

  task automatic send(input logic [7:0] d);
    tick(1, d, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0);
  endtask

  task automatic wait_warm_low();
    for (int i = 0; i < 3000 && kif.o_warm_reset; i++) idle(1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         blk;
    bit         osd;
    logic [7:0] cmd;
    bit         f11m;
  } vec_t;

  vec_t vt[$];
  logic [7:0] pool[13] = '{8'h07, 8'h78, 8'h7E, 8'h14, 8'h11, 8'h71, 8'hE0,
                          8'hF0, 8'hE1, 8'h12, 8'h59, 8'h1C, 8'h77};

  initial begin
    kif.scan_valid = 0;
    kif.scan_data  = 0;

    // reset state
    for (int i = 0; i < 3; i++) tick(0, 8'h00, 1);
    chk("rst_cmd", kif.osd_command, 8'h00);
    chk("rst_warm", kif.o_warm_reset, 1'b0);
    chk("rst_f11", kif.o_f11_make, 1'b0);

    // directed table: F12 make/break, ScrollLock repeats, F11 strobe, ext/fake codes
    vt = '{'{8'h07, 1, 0, 8'h02, 0}, '{8'hF0, 1, 0, 8'h02, 0}, '{8'h07, 0, 0, 8'h00, 0},
           '{8'h7E, 0, 1, 8'h01, 0}, '{8'h7E, 0, 1, 8'h01, 0}, '{8'h7E, 0, 1, 8'h01, 0},
           '{8'hF0, 0, 1, 8'h01, 0}, '{8'h7E, 0, 0, 8'h00, 0},
           '{8'h78, 0, 0, 8'h04, 1}, '{8'h78, 0, 0, 8'h04, 0}, '{8'hF0, 0, 0, 8'h04, 0},
           '{8'h78, 0, 0, 8'h00, 0},
           '{8'hE0, 0, 0, 8'h00, 0}, '{8'h07, 0, 0, 8'h00, 0},
           '{8'hE0, 0, 0, 8'h00, 0}, '{8'h12, 0, 0, 8'h00, 0},
           '{8'h71, 0, 0, 8'h00, 0}, '{8'hF0, 0, 0, 8'h00, 0}, '{8'h71, 0, 0, 8'h00, 0}};
    foreach (vt[i]) begin
      send(vt[i].data);
      chk($sformatf("tbl%0d_blk", i), kif.key_blksbr, vt[i].blk);
      chk($sformatf("tbl%0d_osd", i), kif.key_osd, vt[i].osd);
      chk($sformatf("tbl%0d_cmd", i), kif.osd_command, vt[i].cmd);
      chk($sformatf("tbl%0d_f11", i), kif.o_f11_make, vt[i].f11m);
      chk($sformatf("tbl%0d_warm", i), kif.o_warm_reset, 1'b0);
    end

    // Pause swallowed; Ctrl must not be latched from it
    foreach (pool[i]) ;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_cmd", kif.osd_command, 8'h00);
    send(8'h07);
    chk("pause_then_f12", kif.key_blksbr, 1'b1);
    send(8'hE0); send(8'h11); send(8'hE0); send(8'h71);
    idle(1);
    chk("alt_del_no_ctrl", kif.o_warm_reset, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hF0); send(8'h07);

    // Ctrl+Alt+Del pulse, re-press during pulse must not extend
    send(8'h14);
    wr_cycles = 0;
    send(8'hE0); send(8'h71);
    chk("warm_rise", kif.o_warm_reset, 1'b1);
    idle(50);
    send(8'hE0); send(8'h71);
    idle(20);
    send(8'hE0); send(8'hF0); send(8'h71);
    send(8'hE0); send(8'h71);
    wait_warm_low();
    chk("warm_len1", wr_cycles, R_LEN);
    send(8'hE0); send(8'hF0); send(8'h71);
    wr_cycles = 0;
    send(8'hE0); send(8'h71);
    chk("warm_rise2", kif.o_warm_reset, 1'b1);
    wait_warm_low();
    chk("warm_len2", wr_cycles, R_LEN);
    send(8'hE0); send(8'hF0); send(8'h71);

    // Prefix timeout: full gap abandons E0, one cycle less still decodes Del
    send(8'hE0); idle(T_OUT); send(8'h71);
    idle(2);
    chk("timeout_no_del", kif.o_warm_reset, 1'b0);
    send(8'hF0); send(8'h71);
    send(8'hE0); idle(T_OUT - 1); send(8'h71);
    chk("gap_edge_del", kif.o_warm_reset, 1'b1);

    // reset mid-pulse and mid-break
    idle(5);
    tick(0, 8'h00, 1);
    chk("rst_mid_warm", kif.o_warm_reset, 1'b0);
    send(8'h07); send(8'hF0);
    tick(0, 8'h00, 1);
    chk("rst_mid_blk", kif.key_blksbr, 1'b0);
    send(8'h07);
    chk("rst_then_make", kif.key_blksbr, 1'b1);

    // random byte streams with idle bursts and occasional reset
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 90) send(pool[$urandom_range(0, 12)]);
      else if (r < 92) idle(T_OUT + $urandom_range(0, 4) - 2);
      else if (r == 199) tick(0, 8'h00, 1);
      else idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/specialkey_scanner.md
# specialkey_scanner

Decodes the PS/2 set-2 scancode byte stream into the special-key levels consumed by the special-key handler: F12 (BLK+SBR), ScrollLock (OSD/HOLD), F11, and a Ctrl+Alt+Del warm-reset pulse. It sits between the PS/2 byte receiver and the special-key handler, in parallel with the matrix keyboard decoder. It tracks make/break state across E0/F0 prefixes, swallows the Pause sequence, and filters typematic repeats.

## Interface
- PREFIX_TIMEOUT, default 24'd3000000: idle cycles after which a pending prefix is abandoned.
- RESET_LEN, default 16'd1024: width of `o_warm_reset` in clk cycles.
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low, sampled on the rising edge of `clk`.
- scan_data  in  8  received scancode byte; valid only while `scan_valid` is high.
- scan_valid  in  1  one-cycle strobe per received byte.
- key_blksbr  out  1  F12 held.
- key_osd  out  1  ScrollLock held.
- osd_command  out  8  {5'b0, F11 held, F12 held, ScrollLock held}.
- o_warm_reset  out  1  Ctrl+Alt+Del pulse, RESET_LEN cycles.
- o_f11_make  out  1  one-cycle strobe on F11 press; not repeated while F11 is held.

## Operation
- Reset values: all outputs 0, all held flags 0, FSM in IDLE, counters 0.
- Byte FSM, advanced only on `scan_valid`:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip=7; any other byte -> make(code, ext=0).
  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; any other byte -> make(code, ext=1), then IDLE.
  - BRK: byte -> break(code, ext=0), then IDLE.
  - EXTBRK: byte -> break(code, ext=1), then IDLE.
  - PAUSE: skip decrements on each byte; at 0 -> IDLE. Bytes in PAUSE never reach make/break.
- Key matching; make sets the held flag, break clears it:
  - F12: 07, ext=0.
  - F11: 78, ext=0.
  - ScrollLock: 7E, ext=0.
  - LCtrl: 14, ext=0. RCtrl: 14, ext=1. Ctrl = LCtrl | RCtrl.
  - LAlt: 11, ext=0. RAlt: 11, ext=1. Alt = LAlt | RAlt.
  - Del: 71, ext=1. Keypad '.' (71, ext=0) is not Del.
- Unmatched codes are ignored. E0 12 / E0 59 fake shifts are ignored.
- Typematic filter:
  - A make of an already-held key changes nothing.
  - `o_f11_make` fires only on the 0->1 transition of F11 held.
  - Warm reset triggers only on the 0->1 transition of Del held while Ctrl && Alt are held.
- Warm reset:
  - On trigger, `o_warm_reset` goes to 1 and the counter loads RESET_LEN-1. The output stays high until the counter reaches 0.
  - A trigger while already active is ignored; there is no extension.
- Prefix timeout:
  - In EXT, BRK, EXTBRK or PAUSE, a counter counts cycles without `scan_valid`. Reaching PREFIX_TIMEOUT forces IDLE with no key effect.
  - The counter clears on every byte and while in IDLE.
- `reset_n` low mid-sequence:
  - Aborts the FSM, clears all held flags and clears `o_warm_reset` on the same edge.
  - The next byte is decoded from IDLE.

## Timing
- Output latency: `key_*`, `osd_command`, `o_f11_make` and the rise of `o_warm_reset` change on the clk edge after the edge sampling the final byte of a sequence.
- FSM update on a prefix byte: one cycle.
- `o_f11_make` is exactly one cycle high.
- `o_warm_reset` is high for exactly RESET_LEN cycles.
- Back-to-back strobes: `scan_valid` may be high on consecutive cycles and every byte must be consumed.
- Timeout coincidence: a byte arriving in the same cycle the timeout count is reached is decoded in the current state. The byte wins over the timeout.

## Structure
- Shared package `kbd_pkg`:
  - Scancode constants: SC_E0, SC_E1, SC_F0, SC_F11, SC_F12, SC_SCRL, SC_CTRL, SC_ALT, SC_DEL.
  - FSM state encoding: IDLE, EXT, BRK, EXTBRK, PAUSE.
  - osd_command bit indices.
- One sub-module, `pulse_stretch`: trigger in, RESET_LEN-parameterised counter, level out. It produces `o_warm_reset`.
- All other logic stays flat in `specialkey_scanner`.

## Test plan
- Bytes 07, F0 07 -> `key_blksbr` and `osd_command[1]` are 1 one cycle after 07, and 0 one cycle after the second 07.
- Bytes 7E, 7E, 7E, F0 7E -> `key_osd` rises once and stays 1 through the repeats. Bytes 78, 78 -> `o_f11_make` is high exactly one cycle.
- Bytes 14, E0 11, E0 71 -> `o_warm_reset` high for 1024 cycles. Further E0 71 repeats during the pulse -> no extension. Bytes E0 F0 71 then E0 71 after the pulse ends -> a second pulse.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 07 -> no Ctrl flag set and no output change during Pause; `key_blksbr`=1 after the 07.
- Byte E0, then 3000000 idle cycles, then 71 -> treated as keypad '.', so no Del; with Ctrl+Alt held, no warm reset.
- F12 held, `reset_n` low for 1 cycle between F0 and 07 -> `key_blksbr`=0 after reset. The trailing 07 is decoded as a new make, so `key_blksbr`=1.
